// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter_pkg
//  Purpose  : Shared definitions for the iterative radix-2 divider. Provides
//             the default operand width, the divider FSM state encodings and
//             the EX-stage opcode to (in_signed, in_rem) decode.
//  Revision : 1.0  initial release
// ============================================================================
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_FIX  = 2'd2,
        DIV_ST_DONE = 2'd3
    } div_state_e;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_MOD  = 2'd1,
        OP_DIVU = 2'd2,
        OP_MODU = 2'd3
    } div_op_e;

    typedef struct packed {
        logic is_signed;
        logic is_rem;
    } div_ctl_t;

    // EX-stage decode: which of the four divide ops maps to which controls.
    function automatic div_ctl_t div_op_decode(input div_op_e op);
        div_ctl_t c;
        c.is_signed = (op == OP_DIV) || (op == OP_MOD);
        c.is_rem    = (op == OP_MOD) || (op == OP_MODU);
        return c;
    endfunction

endpackage : div_iter_pkg
`default_nettype wire

// File: rtl/div_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter_if
//  Purpose  : Request/response handshake bundle of the iterative divider.
//             master = requester/consumer (EX stage), slave = divider.
//  Signals  : in_valid/in_ready/in_signed/in_rem/in_dividend/in_divisor
//             out_valid/out_ready/out_result/out_dbz
//  Revision : 1.0  initial release
// ============================================================================
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic             in_rem;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_dbz;

    modport master (
        output in_valid, in_signed, in_rem, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, out_result, out_dbz
    );

    modport slave (
        input  in_valid, in_signed, in_rem, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, out_result, out_dbz
    );
endinterface : div_iter_if
`default_nettype wire

// File: rtl/div_iter_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_step
//  Purpose  : One combinational restoring-division step. Shifts the next
//             dividend bit into the partial remainder and subtracts the
//             divisor when it fits.
//  Ports    : i_rem     partial remainder (always < i_divisor)
//             i_bit     next dividend bit, MSB first
//             i_divisor unsigned divisor magnitude
//             o_rem     updated partial remainder
//             o_qbit    quotient bit produced by this step
//  Revision : 1.0  initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);
    // {rem, bit} is WIDTH+1 bits wide; one more bit carries the borrow.
    logic [WIDTH+1:0] w_trial;
    logic [WIDTH:0]   w_shift;

    assign w_shift = {i_rem, i_bit};
    assign w_trial = {1'b0, w_shift} - {2'b00, i_divisor};
    assign o_qbit  = ~w_trial[WIDTH+1];

    // Because i_rem < divisor, both the difference and a restored shift
    // value fit in WIDTH bits.
    assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
endmodule : div_step
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Purpose  : Iterative radix-2 restoring divider, signed or unsigned,
//             returning quotient or remainder. One quotient bit per cycle,
//             deterministic divide-by-zero and MIN/-1 results.
//  Ports    : clk     clock, all state changes on posedge
//             rst_n   synchronous active-low reset
//             flush   aborts any in-flight or just-offered request
//             bus     div_iter_if.slave request/response handshake
//  Revision : 1.0  initial release
// ============================================================================
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    div_iter_if.slave bus
);

    div_state_e       r_state;
    div_state_e       w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_b;          // |divisor|
    logic [WIDTH-1:0] r_rem;        // partial remainder
    logic [WIDTH-1:0] r_dvd_orig;   // untouched dividend for the dbz remainder
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_rem_sel;
    logic             r_dbz;
    logic [WIDTH-1:0] r_result;
    logic             r_out_dbz;

    logic             w_accept;
    logic             w_calc_last;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_qbit;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic [WIDTH-1:0] w_fix_result;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign bus.in_ready   = (r_state == DIV_ST_IDLE);
    assign bus.out_valid  = (r_state == DIV_ST_DONE);
    assign bus.out_result = r_result;
    assign bus.out_dbz    = r_out_dbz;

    // A flush in the accepting cycle discards the request.
    assign w_accept    = bus.in_valid && (r_state == DIV_ST_IDLE) && !flush;
    assign w_calc_last = (r_cnt == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Operand magnitudes. |MIN| is 2^(WIDTH-1) read unsigned, which is
    // what makes MIN/-1 come out as MIN with no special case.
    // ------------------------------------------------------------------
    assign w_a_neg = bus.in_signed && bus.in_dividend[WIDTH-1];
    assign w_b_neg = bus.in_signed && bus.in_divisor[WIDTH-1];
    assign w_a_abs = w_a_neg ? (-bus.in_dividend) : bus.in_dividend;
    assign w_b_abs = w_b_neg ? (-bus.in_divisor)  : bus.in_divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_a[WIDTH-1]),
        .i_divisor (r_b),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    // ------------------------------------------------------------------
    // Sign fix-up and final selection
    // ------------------------------------------------------------------
    assign w_q_fix = r_q_neg ? (-r_a)   : r_a;
    assign w_r_fix = r_r_neg ? (-r_rem) : r_rem;

    always_comb begin
        w_fix_result = r_rem_sel ? w_r_fix : w_q_fix;
        if (r_dbz) begin
            w_fix_result = r_rem_sel ? r_dvd_orig : {WIDTH{1'b1}};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= DIV_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = DIV_ST_IDLE;
        end else begin
            case (r_state)
                DIV_ST_IDLE: if (w_accept)      w_state_nxt = DIV_ST_CALC;
                DIV_ST_CALC: if (w_calc_last)   w_state_nxt = DIV_ST_FIX;
                DIV_ST_FIX:                     w_state_nxt = DIV_ST_DONE;
                DIV_ST_DONE: if (bus.out_ready) w_state_nxt = DIV_ST_IDLE;
                default:                        w_state_nxt = DIV_ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rem      <= '0;
            r_dvd_orig <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_rem_sel  <= 1'b0;
            r_dbz      <= 1'b0;
            r_result   <= '0;
            r_out_dbz  <= 1'b0;
        end else begin
            case (r_state)
                DIV_ST_IDLE: begin
                    if (w_accept) begin
                        r_a        <= w_a_abs;
                        r_b        <= w_b_abs;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                        r_dvd_orig <= bus.in_dividend;
                        r_q_neg    <= w_a_neg ^ w_b_neg;
                        r_r_neg    <= w_a_neg;
                        r_rem_sel  <= bus.in_rem;
                        r_dbz      <= (bus.in_divisor == '0);
                    end
                end
                DIV_ST_CALC: begin
                    r_a   <= {r_a[WIDTH-2:0], w_qbit};
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                DIV_ST_FIX: begin
                    if (!flush) begin
                        r_result  <= w_fix_result;
                        r_out_dbz <= r_dbz;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_iter
//  Purpose  : Self-checking bench for div_iter (WIDTH=32). Expected results
//             come from a 64-bit reference divide and are queued on accept,
//             then popped when the divider presents a result.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_iter;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic r);
        exp_t        e;
        longint      sa, sbv, q, m;
        logic [63:0] ua, ub;
        e.dbz = (b == '0);
        if (b == '0) begin
            e.res = r ? a : {W{1'b1}};
            return e;
        end
        if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = sa / sbv;
            m   = sa % sbv;
        end else begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            q  = longint'(ua / ub);
            m  = longint'(ua % ub);
        end
        e.res = r ? m[W-1:0] : q[W-1:0];
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one request; returns #1 after the accepting edge. Inputs are
    // scrambled afterwards so any late sampling shows up as a wrong result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic r, input bit push);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        bus.in_signed   = s;
        bus.in_rem      = r;
        tick();
        bus.in_valid    = 1'b0;
        bus.in_dividend = $urandom;
        bus.in_divisor  = $urandom;
        bus.in_signed   = 1'($urandom);
        bus.in_rem      = 1'($urandom);
        if (push) sb.push_back(model(a, b, s, r));
    endtask

    // Waits for the result (edges counted from the accepting edge = 1),
    // compares it, applies bp cycles of backpressure, then handshakes.
    task automatic collect(input string tag, input int exp_lat, input int bp);
        int           n = 1;
        exp_t         e;
        logic [W-1:0] held;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        if (bus.out_valid !== 1'b1) return;
        if (exp_lat > 0) check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_res"}, {32'd0, bus.out_result}, {32'd0, e.res});
        check({tag, "_dbz"}, {63'd0, bus.out_dbz}, {63'd0, e.dbz});
        held = bus.out_result;
        for (int i = 0; i < bp; i++) begin
            tick();
            check({tag, "_bp_valid"}, {63'd0, bus.out_valid}, 64'd1);
            check({tag, "_bp_res"}, {32'd0, bus.out_result}, {32'd0, held});
            check({tag, "_bp_inrdy"}, {63'd0, bus.in_ready}, 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_post_inrdy"}, {63'd0, bus.in_ready}, 64'd1);
        check({tag, "_post_valid"}, {63'd0, bus.out_valid}, 64'd0);
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic r, input int bp);
        send(a, b, s, r, 1'b1);
        collect(tag, LAT, bp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_inrdy"}, {63'd0, bus.in_ready}, 64'd1);
        check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd0);
        check({tag, "_res"}, {32'd0, bus.out_result}, 64'd0);
        check({tag, "_dbz"}, {63'd0, bus.out_dbz}, 64'd0);
    endtask

    logic [W-1:0] ra, rb;
    bit           seen;
    int           n;

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_signed   = 1'b0;
        bus.in_rem      = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor  = '0;
        bus.out_ready   = 1'b0;
        repeat (3) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Basics
        op("u7d2_q",   32'd7,          32'd2,          1'b0, 1'b0, 0);
        op("u7d2_r",   32'd7,          32'd2,          1'b0, 1'b1, 0);
        op("sm7d2_q",  32'hFFFFFFF9,   32'd2,          1'b1, 1'b0, 0);
        op("sm7d2_r",  32'hFFFFFFF9,   32'd2,          1'b1, 1'b1, 0);
        op("s7dm2_r",  32'd7,          32'hFFFFFFFE,   1'b1, 1'b1, 0);
        op("s7dm2_q",  32'd7,          32'hFFFFFFFE,   1'b1, 1'b0, 0);
        op("uffd2",    32'hFFFFFFFF,   32'd2,          1'b0, 1'b0, 0);
        op("sffd2",    32'hFFFFFFFF,   32'd2,          1'b1, 1'b0, 0);

        // Overflow and divide-by-zero
        op("ovf_q",    32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b0, 0);
        op("ovf_r",    32'h80000000,   32'hFFFFFFFF,   1'b1, 1'b1, 0);
        op("dbz_q",    32'h12345678,   32'd0,          1'b0, 1'b0, 0);
        op("dbz_r",    32'h12345678,   32'd0,          1'b0, 1'b1, 0);
        op("sdbz_r",   32'hFFFFFF00,   32'd0,          1'b1, 1'b1, 0);

        // Backpressure
        op("bp",       32'd7,          32'd2,          1'b0, 1'b0, 10);

        // Flush at cnt=10, then a fresh request
        send(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_inrdy", {63'd0, bus.in_ready}, 64'd1);
        check("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        op("after_flush", 32'd100, 32'd7, 1'b0, 1'b0, 0);

        // Flush coinciding with an offered request discards it
        bus.in_valid    = 1'b1;
        bus.in_dividend = 32'd50;
        bus.in_divisor  = 32'd5;
        flush           = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        check("flush_acc_inrdy", {63'd0, bus.in_ready}, 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        check("flush_acc_noout", {63'd0, seen}, 64'd0);

        // Reset mid-CALC
        send(32'd999, 32'd4, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        check_reset_vals("rst_calc");
        rst_n = 1'b1;
        tick();

        // Reset while holding a result in DONE
        send(32'd77, 32'd5, 1'b0, 1'b0, 1'b0);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("rst_done_pre_res", {32'd0, bus.out_result}, 64'd15);
        rst_n = 1'b0;
        tick();
        check_reset_vals("rst_done");
        rst_n = 1'b1;
        tick();

        // Randomised regression with random backpressure
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'h80000000;
                1:       ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            op("rand", ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_iter
`default_nettype wire

// File: doc/div_iter.md
# div_iter

Parametrised iterative radix-2 divider for the EX stage, successor to the fixed-latency IP-based divider. It performs signed or unsigned division of WIDTH-bit operands and returns either quotient or remainder (DIV.W/MOD.W/DIV.WU/MOD.WU and wider variants). It uses a valid/ready handshake on both sides, so the pipeline can stall on either port and flush an in-flight divide on exception. Divide-by-zero and signed-overflow results are deterministic.

## Interface
- WIDTH, 32: operand/result width; any value ≥ 4.
- CNT_W, $clog2(WIDTH+1): iteration counter width.
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  abort any in-flight operation.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_signed  input  1  1 = two's-complement operands.
- in_rem  input  1  1 = return remainder, 0 = return quotient.
- in_dividend  input  WIDTH  dividend.
- in_divisor  input  WIDTH  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  quotient or remainder.
- out_dbz  output  1  divisor was zero; valid with out_valid.

## Operation
- States: IDLE, CALC, FIX, DONE. in_ready = (state == IDLE).
- IDLE: on in_valid && in_ready, latch in_signed and in_rem.
  - Latch the absolute values of both operands; take abs only when in_signed.
  - Latch q_neg = signed && (a_msb ^ b_msb) and r_neg = signed && a_msb.
  - Latch dbz = (divisor == 0).
  - Clear the partial remainder and set cnt = 0, then go to CALC.
- CALC: one restoring step per cycle, MSB of the dividend first.
  - Compute a (WIDTH+1)-bit trial subtraction: {rem, next dividend bit} − |divisor|.
  - If the trial result is non-negative, take it as rem and shift in quotient bit 1; otherwise keep the shifted value and shift in 0.
  - cnt increments each cycle; after WIDTH steps go to FIX.
- FIX: apply the sign corrections.
  - Quotient is negated if q_neg; remainder is negated if r_neg.
  - Select the final output with in_rem.
  - If dbz, override: quotient = all-ones, remainder = original dividend.
  - Register the result and go to DONE.
- DONE: out_valid = 1, with out_result and out_dbz held stable.
  - On out_ready, go to IDLE.
  - No new request is accepted in the same cycle.
- Overflow: signed MIN / −1 produces quotient MIN (0x80000000 for WIDTH=32) and remainder 0. This falls out of unsigned |MIN| = 2^(WIDTH−1); it needs no special case.
- Priority: rst_n > flush > normal transitions.
  - flush in any state forces IDLE on the next edge and deasserts out_valid.
  - flush in the same cycle as an accept discards that request.
- Remainder sign follows the dividend; quotient truncates toward zero.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_result 0, out_dbz 0, cnt 0.
- Latency: out_valid rises exactly WIDTH+2 clock edges after the accepting edge (1 edge into CALC, WIDTH steps, 1 edge out of FIX). For WIDTH=32 that is 34 edges.
- Throughput: minimum WIDTH+3 cycles per operation with out_ready held high.
- out_valid stays high, with the result unchanged, until the out_ready handshake completes; backpressure has no limit.
- Inputs are sampled only on the accepting edge; changes afterwards have no effect.
- Reset or flush mid-CALC: no result is ever emitted for that request, and in_ready returns to 1 on the next cycle.
- Outputs are registered; there is no combinational path from inputs to outputs except in_ready (state decode).

## Structure
- Shared defs file: DIV_ST_* state encodings and a DIV_WIDTH default. The EX-stage op-to-(in_signed, in_rem) decode also lives there, mapping OP_DIV/OP_MOD/OP_DIVU/OP_MODU.
- One sub-module: div_step, the combinational single restoring step.
  - Inputs: rem, next bit, divisor.
  - Outputs: new rem, quotient bit.
  - Parametrised by WIDTH so a future radix-4 variant can instantiate two.
- The FSM, counter, abs/negate logic and output register stay in div_iter.

## Test plan
- Unsigned and signed basics (WIDTH=32):
  - 7 / 2 unsigned, quotient → 3, 34 edges after accept.
  - Same operands with in_rem → 1.
  - Signed −7 / 2: quotient → 0xFFFFFFFD, remainder → 0xFFFFFFFF.
  - Signed 7 / −2: remainder → 0x00000001.
- Unsigned large operand: 0xFFFFFFFF / 2 with in_signed=0 → 0x7FFFFFFF; the same with in_signed=1 → 0 (−1/2 truncates).
- Overflow and divide-by-zero:
  - 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0, out_dbz 0.
  - 0x12345678 / 0 → quotient 0xFFFFFFFF, remainder 0x12345678, out_dbz 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid and the result are stable and in_ready=0. One cycle after out_ready pulses, in_ready=1.
- Flush at cnt=10, then a new request 100 / 7 → no stale out_valid, and the new result 14 appears exactly 34 edges after its accept.
- Reset asserted during CALC and during DONE → the next edge shows all reset values. Randomised regression against a reference model for WIDTH ∈ {8, 32, 64} with random backpressure.
